mul_seq: RTL

//  Iterative radix-2 shift-add multiplier; the multiply-side counterpart to the

---
 rtl/mul_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU.
// Produces one partial product per clock, with a start/busy/done handshake.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // Upper half accumulates partial sums; lower half holds the multiplier,
    // which shifts out from the bottom as product bits shift in from the top.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_shift;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        // The most-negative operand's magnitude still fits unsigned in WIDTH bits.
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_shift = {sum, acc_q[WIDTH-1:1]};
        prod_fix  = neg_q ? -acc_shift : acc_shift;

        if (start) begin
            state_d = S_RUN;
            count_d = '0;
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state_q == S_RUN) begin
            acc_d   = acc_shift;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
                state_d      = S_IDLE;
                count_d      = '0;
                done_d       = 1'b1;
                {hi_d, lo_d} = prod_fix;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
